// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : prog_load_ctrl
// Purpose  : Boot/load sequencer for the RISC CPU family. It accepts a stream
//            of (address, data) words over a valid/ready handshake and writes
//            them into CPU RAM while the CPU is held disabled. It then releases
//            the CPU run enable, watches for done with a cycle timeout, and
//            counts changes on the CPU output bus.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_load   in   single-cycle pulse, begins a load session
//   abort        in   synchronous return to IDLE, highest priority
//   run_req      in   level, permits ARM -> RUN
//   load_valid   in   load word valid
//   load_ready   out  block can accept a word
//   load_addr    in   target RAM address
//   load_data    in   word to write
//   load_last    in   marks the final word of the session
//   Ram_addr     out  RAM write address to CPU
//   Ram_data     out  RAM write data to CPU
//   WR_RAM_E     out  RAM write enable to CPU
//   E            out  CPU run enable
//   done         in   CPU halted
//   out_data     in   CPU output bus, monitored during RUN
//   state        out  IDLE=0 LOAD=1 WRITE=2 ARM=3 RUN=4 DONE=5 TMO=6
//   word_cnt     out  number of in-range words written this session
//   checksum     out  sum mod 2^DATA_W of written data
//   addr_err     out  sticky, an out-of-range word was received
//   chg_cnt      out  saturating count of out_data changes during RUN
//   last_out     out  most recent out_data sampled in RUN
// ============================================================================
module prog_load_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int MEM_DEPTH  = 65536,
    parameter int TMO_W      = 24,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              abort,
    input  logic              run_req,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic [ADDR_W-1:0] Ram_addr,
    output logic [DATA_W-1:0] Ram_data,
    output logic              WR_RAM_E,
    output logic              E,
    input  logic              done,
    input  logic [DATA_W-1:0] out_data,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   word_cnt,
    output logic [DATA_W-1:0] checksum,
    output logic              addr_err,
    output logic [15:0]       chg_cnt,
    output logic [DATA_W-1:0] last_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_ARM   = 3'd3,
        S_RUN   = 3'd4,
        S_DONE  = 3'd5,
        S_TMO   = 3'd6
    } state_t;

    // Depth is compared one bit wider than the address so that a depth of
    // exactly 2^ADDR_W (every address valid) is representable.
    localparam logic [ADDR_W:0]  c_depth    = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]  c_cnt_one  = (ADDR_W+1)'(1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TMO_CYCLES - 1);
    localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
    localparam logic [15:0]      c_chg_max  = 16'hFFFF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_load_ready;
    logic              r_wr;
    logic              r_e;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic [ADDR_W:0]   r_word_cnt;
    logic [DATA_W-1:0] r_checksum;
    logic              r_addr_err;
    logic [15:0]       r_chg_cnt;
    logic [DATA_W-1:0] r_last_out;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_last_word;  // accepted in-range word carried load_last

    logic              w_accept;
    logic              w_in_range;
    logic              w_tmo_hit;

    assign w_accept   = (r_state == S_LOAD) && load_valid && r_load_ready;
    assign w_in_range = ({1'b0, load_addr} < c_depth);
    assign w_tmo_hit  = (r_tmo_cnt == c_tmo_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start_load) w_state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_in_range)     w_state_nxt = S_WRITE;
                        else if (load_last) w_state_nxt = S_ARM;
                    end
                end
                S_WRITE: begin
                    w_state_nxt = r_last_word ? S_ARM : S_LOAD;
                end
                S_ARM: begin
                    if (run_req) w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    // done has priority over a timeout in the same cycle
                    if (done)           w_state_nxt = S_DONE;
                    else if (w_tmo_hit) w_state_nxt = S_TMO;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register; enables are registered from the next state so they
    // line up exactly with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_load_ready <= 1'b0;
            r_wr         <= 1'b0;
            r_e          <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_load_ready <= (w_state_nxt == S_LOAD);
            r_wr         <= (w_state_nxt == S_WRITE);
            r_e          <= (w_state_nxt == S_RUN);
        end
    end

    // ------------------------------------------------------------------
    // Datapath and status. abort freezes everything here: counters hold.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_data  <= '0;
            r_word_cnt  <= '0;
            r_checksum  <= '0;
            r_addr_err  <= 1'b0;
            r_chg_cnt   <= '0;
            r_last_out  <= '0;
            r_tmo_cnt   <= '0;
            r_last_word <= 1'b0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE, S_DONE, S_TMO: begin
                    if (start_load) begin
                        r_word_cnt  <= '0;
                        r_checksum  <= '0;
                        r_addr_err  <= 1'b0;
                        r_chg_cnt   <= '0;
                        r_last_out  <= '0;
                        r_last_word <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_ram_addr  <= load_addr;
                            r_ram_data  <= load_data;
                            r_word_cnt  <= r_word_cnt + c_cnt_one;
                            r_checksum  <= r_checksum + load_data;
                            r_last_word <= load_last;
                        end else begin
                            r_addr_err  <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (run_req) begin
                        r_tmo_cnt  <= '0;
                        r_last_out <= out_data;
                    end
                end
                S_RUN: begin
                    if (out_data != r_last_out) begin
                        r_last_out <= out_data;
                        if (r_chg_cnt != c_chg_max) r_chg_cnt <= r_chg_cnt + 16'd1;
                    end
                    if (!done && !w_tmo_hit) r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
                end
                default: ;
            endcase
        end
    end

    assign state      = r_state;
    assign load_ready = r_load_ready;
    assign WR_RAM_E   = r_wr;
    assign E          = r_e;
    assign Ram_addr   = r_ram_addr;
    assign Ram_data   = r_ram_data;
    assign word_cnt   = r_word_cnt;
    assign checksum   = r_checksum;
    assign addr_err   = r_addr_err;
    assign chg_cnt    = r_chg_cnt;
    assign last_out   = r_last_out;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_load_ctrl
// Purpose  : Self-checking bench for prog_load_ctrl. A session-level model of
//            the sequencer predicts every registered output each cycle; a
//            write scoreboard holds the words that must reach the RAM port.
//            Directed scenarios pin the model with hand-computed values, then
//            randomized sessions exercise loading, address errors, done and
//            timeout endings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 16;
    localparam int MEM_DEPTH  = 256;
    localparam int TMO_W      = 24;
    localparam int TMO_CYCLES = 48;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_load = 1'b0;
    logic              abort = 1'b0;
    logic              run_req = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_last = 1'b0;
    logic [ADDR_W-1:0] Ram_addr;
    logic [DATA_W-1:0] Ram_data;
    logic              WR_RAM_E;
    logic              E;
    logic              done = 1'b0;
    logic [DATA_W-1:0] out_data = '0;
    logic [2:0]        state;
    logic [ADDR_W:0]   word_cnt;
    logic [DATA_W-1:0] checksum;
    logic              addr_err;
    logic [15:0]       chg_cnt;
    logic [DATA_W-1:0] last_out;

    prog_load_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH),
        .TMO_W(TMO_W), .TMO_CYCLES(TMO_CYCLES)
    ) u_dut (
        .CLK(CLK), .rst_n(rst_n), .start_load(start_load), .abort(abort),
        .run_req(run_req), .load_valid(load_valid), .load_ready(load_ready),
        .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .Ram_addr(Ram_addr), .Ram_data(Ram_data), .WR_RAM_E(WR_RAM_E), .E(E),
        .done(done), .out_data(out_data), .state(state), .word_cnt(word_cnt),
        .checksum(checksum), .addr_err(addr_err), .chg_cnt(chg_cnt),
        .last_out(last_out)
    );

    always #5 CLK = ~CLK;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    logic [31:0] exp_q[$];

    always @(posedge CLK) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Session-level model. Modes use the published state numbering.
    // ------------------------------------------------------------------
    int m_mode = 0, m_addr = 0, m_data = 0, m_cnt = 0, m_sum = 0;
    int m_chg = 0, m_last = 0, m_run = 0;
    bit m_err = 0, m_pend_last = 0;

    function void m_reset();
        m_mode = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_sum = 0;
        m_chg = 0; m_last = 0; m_run = 0; m_err = 0; m_pend_last = 0;
    endfunction

    function void m_step();
        if (abort) begin
            m_mode = 0;
            return;
        end
        if (m_mode == 0 || m_mode == 5 || m_mode == 6) begin
            if (start_load) begin
                m_mode = 1; m_cnt = 0; m_sum = 0; m_err = 0; m_chg = 0; m_last = 0;
            end
        end else if (m_mode == 1) begin
            if (load_valid) begin
                if (int'(load_addr) < MEM_DEPTH) begin
                    m_addr = int'(load_addr);
                    m_data = int'(load_data);
                    m_cnt  = m_cnt + 1;
                    m_sum  = (m_sum + int'(load_data)) % 65536;
                    m_pend_last = load_last;
                    m_mode = 2;
                end else begin
                    m_err = 1;
                    if (load_last) m_mode = 3;
                end
            end
        end else if (m_mode == 2) begin
            m_mode = m_pend_last ? 3 : 1;
        end else if (m_mode == 3) begin
            if (run_req) begin
                m_mode = 4; m_run = 0; m_last = int'(out_data);
            end
        end else if (m_mode == 4) begin
            if (int'(out_data) != m_last) begin
                m_last = int'(out_data);
                m_chg  = (m_chg < 65535) ? m_chg + 1 : 65535;
            end
            m_run = m_run + 1;  // RUN cycles completed so far
            if (done)                     m_mode = 5;
            else if (m_run == TMO_CYCLES) m_mode = 6;
        end
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    // ------------------------------------------------------------------
    // Per-cycle compare, away from the active edge
    // ------------------------------------------------------------------
    always @(negedge CLK) begin : p_cmp
        logic [31:0] w;
        chk("state",      32'(state),      32'(m_mode));
        chk("load_ready", 32'(load_ready), 32'(m_mode == 1));
        chk("WR_RAM_E",   32'(WR_RAM_E),   32'(m_mode == 2));
        chk("E",          32'(E),          32'(m_mode == 4));
        chk("Ram_addr",   32'(Ram_addr),   32'(m_addr));
        chk("Ram_data",   32'(Ram_data),   32'(m_data));
        chk("word_cnt",   32'(word_cnt),   32'(m_cnt));
        chk("checksum",   32'(checksum),   32'(m_sum));
        chk("addr_err",   32'(addr_err),   32'(m_err));
        chk("chg_cnt",    32'(chg_cnt),    32'(m_chg));
        chk("last_out",   32'(last_out),   32'(m_last));
        if (WR_RAM_E === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write", Ram_addr, Ram_data);
            end else begin
                w = exp_q.pop_front();
                chk("sb_wr_addr", 32'(Ram_addr), 32'(w[31:16]));
                chk("sb_wr_data", 32'(Ram_data), 32'(w[15:0]));
                wr_seen++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; every task starts and ends on a falling edge
    // ------------------------------------------------------------------
    task automatic start_session();
        start_load = 1'b1;
        @(negedge CLK);
        start_load = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] d,
                             input bit last, input bit keep);
        int n = 0;
        load_valid = 1'b1; load_addr = a; load_data = d; load_last = last;
        while (load_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            n_vec++; n_err++;
            $display("FAIL handshake_timeout: load_ready %b, required 1", load_ready);
            keep = 1'b0;
        end else begin
            @(posedge CLK);
            if (int'(a) < MEM_DEPTH) exp_q.push_back({a, d});
        end
        @(negedge CLK);
        if (!keep) begin
            load_valid = 1'b0; load_last = 1'b0;
        end
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
    endtask

    initial begin
        int c0, w0, k, nw;
        logic [15:0] a;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_state",    32'(state),      32'd0);
        chk("rst_E",        32'(E),          32'd0);
        chk("rst_wr",       32'(WR_RAM_E),   32'd0);
        chk("rst_ready",    32'(load_ready), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge CLK);

        // Basic load of three words
        start_session();
        send_word(16'h0000, 16'h1234, 1'b0, 1'b0);
        send_word(16'h0001, 16'h00FF, 1'b0, 1'b0);
        send_word(16'h0002, 16'h8000, 1'b1, 1'b0);
        @(negedge CLK);
        chk("load_word_cnt", 32'(word_cnt), 32'd3);
        chk("load_checksum", 32'(checksum), 32'h9333);
        chk("load_in_arm",   32'(state),    32'd3);
        chk("load_writes",   32'(wr_seen),  32'd3);
        run_req = 1'b1;
        @(negedge CLK);
        chk("run_E", 32'(E), 32'd1);

        // Done ending with out_data 0 -> 5 -> 5 -> 7
        for (int i = 0; i <= 40; i++) begin
            out_data = (i == 0) ? 16'h0000 : (i <= 2) ? 16'h0005 : 16'h0007;
            done = (i == 40);
            @(negedge CLK);
        end
        done = 1'b0; run_req = 1'b0;
        chk("done_state",    32'(state),    32'd5);
        chk("done_E",        32'(E),        32'd0);
        chk("done_chg_cnt",  32'(chg_cnt),  32'd2);
        chk("done_last_out", 32'(last_out), 32'h0007);

        // Timeout with done held low
        start_session();
        send_word(16'h0005, 16'h0042, 1'b1, 1'b0);
        @(negedge CLK);
        run_req = 1'b1;
        @(negedge CLK);
        k = 0;
        while (state == 3'd4 && k < 200) begin
            k++;
            @(negedge CLK);
        end
        run_req = 1'b0;
        chk("tmo_run_cycles", 32'(k),     32'd48);
        chk("tmo_state",      32'(state), 32'd6);
        chk("tmo_E",          32'(E),     32'd0);

        // done coinciding with the final timeout cycle
        start_session();
        send_word(16'h0006, 16'h0001, 1'b1, 1'b0);
        @(negedge CLK);
        run_req = 1'b1;
        @(negedge CLK);
        repeat (47) @(negedge CLK);
        done = 1'b1;
        @(negedge CLK);
        done = 1'b0; run_req = 1'b0;
        chk("coincide_state", 32'(state), 32'd5);

        // Out-of-range word between two valid ones
        start_session();
        send_word(16'h0010, 16'hAAAA, 1'b0, 1'b0);
        send_word(16'h0100, 16'h5555, 1'b0, 1'b0);
        send_word(16'h0011, 16'h0001, 1'b1, 1'b0);
        @(negedge CLK);
        chk("aerr_word_cnt", 32'(word_cnt), 32'd2);
        chk("aerr_flag",     32'(addr_err), 32'd1);
        chk("aerr_checksum", 32'(checksum), 32'hAAAB);
        do_abort();

        // Out-of-range word carrying load_last goes straight to ARM
        start_session();
        send_word(16'h0020, 16'h1111, 1'b0, 1'b0);
        send_word(16'h0200, 16'h2222, 1'b1, 1'b0);
        chk("aerr_last_arm", 32'(state), 32'd3);
        do_abort();

        // Abort while a write is on the RAM port
        start_session();
        send_word(16'h0030, 16'h3333, 1'b0, 1'b0);
        chk("abort_in_write", 32'(WR_RAM_E), 32'd1);
        do_abort();
        chk("abort_state",    32'(state),    32'd0);
        chk("abort_wr",       32'(WR_RAM_E), 32'd0);
        chk("abort_word_cnt", 32'(word_cnt), 32'd1);

        // Back-to-back: valid held high for eight words
        start_session();
        c0 = cyc; w0 = wr_seen;
        for (int i = 0; i < 8; i++)
            send_word(16'(16'h0040 + i), 16'($urandom), (i == 7), (i != 7));
        chk("b2b_cycles", 32'(cyc - c0), 32'd15);
        @(negedge CLK);
        chk("b2b_writes", 32'(wr_seen - w0), 32'd8);

        // Asynchronous reset in the middle of RUN
        run_req = 1'b1;
        repeat (4) begin
            out_data = 16'($urandom_range(0, 3));
            @(negedge CLK);
        end
        @(posedge CLK);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_E",        32'(E),          32'd0);
        chk("arst_state",    32'(state),      32'd0);
        chk("arst_ready",    32'(load_ready), 32'd0);
        chk("arst_ram_addr", 32'(Ram_addr),   32'd0);
        chk("arst_word_cnt", 32'(word_cnt),   32'd0);
        chk("arst_chg_cnt",  32'(chg_cnt),    32'd0);
        run_req = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
        @(negedge CLK);

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            start_session();
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 2)) @(negedge CLK);
                a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(256, 600))
                                                : 16'($urandom_range(0, 255));
                send_word(a, 16'($urandom), (w == nw - 1), 1'b0);
            end
            repeat ($urandom_range(1, 3)) @(negedge CLK);
            run_req = 1'b1;
            @(negedge CLK);
            k = 0;
            while (state == 3'd4 && k < 100) begin
                out_data   = 16'($urandom_range(0, 3));
                done       = ($urandom_range(0, 49) == 0);
                start_load = ($urandom_range(0, 9) == 0);
                load_valid = $urandom_range(0, 1);
                load_addr  = 16'($urandom_range(0, 255));
                @(negedge CLK);
                k++;
            end
            done = 1'b0; start_load = 1'b0; load_valid = 1'b0; run_req = 1'b0;
            @(negedge CLK);
        end

        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound so the run always ends on its own
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time exhausted, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
